regfile_banked: RTL and testbench
=================================

Name: regfile_banked

Overview:
Parametrised general-purpose register file for the MIPS core datapath. It is the successor to the fixed 32x32, two-read-port register file. It adds configurable width, depth and read-port count, true per-byte write enables and an optional hardwired-zero entry 0. It also adds optional write-to-read bypass and a sequential clear engine that zeroes the array one entry per cycle after reset or on request, reporting progress through busy/clr_done.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NRD, 2, number of independent read ports
ZERO_R0, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset
clr_req  input  1  request a full-array clear; sampled only in IDLE
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_be  input  DATA_W/8  byte-lane write enables; bit i controls bits [8i+7:8i]
wr_data  input  DATA_W  write data
rd_addr  input  NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  output  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
busy  output  1  clear engine active; array is not accessible
clr_done  output  1  one-cycle pulse when a clear completes

Behaviour:
- Clocking and reset: one clock (CLK); reset RST is synchronous and active-high.
- FSM states:
  - IDLE: normal access.
  - CLEAR: sequential zeroing; a pointer clr_ptr (ADDR_W bits) selects the entry.
- RST high at an edge: state <= CLEAR, clr_ptr <= 0, busy <= 1, clr_done <= 0. No array entry is written while RST is high.
- RST asserted mid-clear restarts the clear from entry 0.
- Array contents are undefined until the first clear completes.
- CLEAR, each edge with RST low:
  - mem[clr_ptr] <= 0 and clr_ptr <= clr_ptr+1.
  - On the edge that clears entry DEPTH-1: state <= IDLE, busy <= 0, clr_done <= 1.
  - A full clear therefore takes exactly DEPTH cycles after RST falls.
- clr_done is high for exactly one cycle (the first IDLE cycle), then returns to 0.
- IDLE, clr_req high at an edge: state <= CLEAR, clr_ptr <= 0, busy <= 1. That edge writes nothing; the clear takes DEPTH further edges.
- clr_req while busy is ignored; it is not queued.
- Writes, IDLE only, wr_en high:
  - Each lane i with wr_be[i]=1 is updated with wr_data lane i; other lanes keep their value.
  - wr_be=0 writes nothing.
  - wr_addr=0 is dropped when ZERO_R0=1.
- Writes while busy are silently discarded, including the cycle clr_req is accepted.
- Reads are combinational (zero latency) from rd_addr for every port independently.
- rd_data forcing order:
  - busy=1: all rd_data = 0.
  - ZERO_R0=1 and rd_addr=0: rd_data = 0, regardless of bypass.
  - Otherwise rd_data = mem[rd_addr].
- Bypass (BYPASS=1, busy=0, wr_en=1, wr_addr==rd_addr[k]):
  - rd_data[k] = per-lane merge: lanes with wr_be set come from wr_data, the rest from mem.
  - With BYPASS=0, the new value is visible the cycle after the write edge.
- Multiple read ports may read the same address; all see identical data.
- Width rules:
  - clr_ptr wraps naturally at DEPTH.
  - No arithmetic on data.
  - DATA_W not a multiple of 8 is illegal; elaboration must fail.

Test Plan:
1. Hold RST high 3 cycles, release; DEPTH=32 -> busy=1 and rd_data=0 for exactly 32 cycles after release, clr_done pulses 1 cycle at cycle 32, busy=0 thereafter.
2. IDLE: write addr 5 data 0xAABBCCDD be=4'b1111, then be=4'b0101 data 0x11223344 -> mem[5] reads 0xAA22CC44; a write with be=0 leaves it unchanged.
3. BYPASS=1: in the cycle wr_en=1, addr 7, data 0x12345678, be=4'b0011, old mem[7]=0xFFFFFFFF, port0 and port1 read 7 -> both show 0xFFFF5678 combinationally; with BYPASS=0 they show 0xFFFFFFFF until the next cycle.
4. ZERO_R0=1: write 0xDEADBEEF to addr 0 with bypass active -> read addr 0 returns 0 in the same and all later cycles; with ZERO_R0=0 it reads 0xDEADBEEF.
5. Fill entries with nonzero values, pulse clr_req -> busy rises next cycle; a write issued at cycle 10 of the clear is discarded; after 32 cycles all entries read 0 and clr_done pulses once.
6. Assert RST at cycle 15 of a clear for 1 cycle -> clr_ptr restarts at 0 and the clear completes 32 cycles after RST falls, with a single clr_done pulse.

Source files
------------

// File: rtl/regfile_banked.sv
// regfile_banked: parametrised multi-port register file with byte lanes,
// optional hardwired r0, write-to-read bypass and a sequential clear engine.
module regfile_banked #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clr_req,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W/8-1:0]     wr_be,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic                    busy,
  output logic                    clr_done
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("regfile_banked: DATA_W must be a multiple of 8");
  end

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [ADDR_W-1:0]   clr_ptr_nxt;
  logic                done_q;
  logic                done_nxt;
  logic                clr_last;
  logic                clr_we;
  logic                wr_go;
  logic [DATA_W-1:0]   wr_mask;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign clr_last = (clr_ptr == ADDR_W'(DEPTH - 1));

  // state register; reset always (re)starts a clear from entry 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      done_q  <= done_nxt;
    end
  end

  // next-state: clr_req only honoured in IDLE, clear walks all entries
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    done_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  // outputs and array write strobes derived from the current state
  always_comb begin
    busy     = (state == CLEAR);
    clr_done = done_q;
    clr_we   = (state == CLEAR);
    wr_go    = (state == IDLE) && !clr_req && wr_en
            && (wr_be != '0)
            && !(ZERO_R0 && (wr_addr == '0));
  end

  // expand byte enables into a bit mask
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NB; i++) begin
      wr_mask[8*i +: 8] = {8{wr_be[i]}};
    end
  end

  // new word for the write address: enabled lanes from wr_data
  always_comb begin
    wr_merged = (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end

  // array update; nothing is written while RST is high
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (clr_we) begin
        mem[clr_ptr] <= '0;
      end else if (wr_go) begin
        mem[wr_addr] <= wr_merged;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] q;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // forcing order: busy, hardwired zero, bypass, array
    always_comb begin
      q = mem[ra];
      if (busy) begin
        q = '0;
      end else if (ZERO_R0 && (ra == '0)) begin
        q = '0;
      end else if (BYPASS && wr_en && (ra == wr_addr)) begin
        q = wr_merged;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = q;
  end

endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: scoreboard bench for regfile_banked, two instances:
// u1 default (bypass, hardwired r0), u2 without bypass and without r0 forcing.
module tb_regfile_banked;

  logic        CLK = 1'b0;
  logic        RST;
  logic        clr_req;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic        busy1;
  logic        busy2;
  logic        done1;
  logic        done2;

  int total = 0;
  int bad   = 0;

  logic [31:0] m1 [32];
  logic [31:0] m2 [32];
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  regfile_banked u1 (
    .CLK(CLK), .RST(RST), .clr_req(clr_req), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1), .clr_done(done1)
  );

  regfile_banked #(.BYPASS(1'b0), .ZERO_R0(1'b0)) u2 (
    .CLK(CLK), .RST(RST), .clr_req(clr_req), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd2), .busy(busy2), .clr_done(done2)
  );

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] obs(input int k);
    case (k)
      0:       return rd1[31:0];
      1:       return rd1[63:32];
      2:       return rd2[31:0];
      default: return rd2[63:32];
    endcase
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [4:0] r0, input logic [4:0] r1);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_addr = {r1, r0};
  endtask

  // expected read values for u1 p0,p1 then u2 p0,p1
  task automatic push_reads();
    logic [4:0] a;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      if (a == 5'd0) exp_q.push_back(32'h0);
      else if (wr_en && a == wr_addr)
        exp_q.push_back(merge(m1[a], wr_data, wr_be));
      else exp_q.push_back(m1[a]);
    end
    for (int p = 0; p < 2; p++) exp_q.push_back(m2[rd_addr[p*5 +: 5]]);
  endtask

  task automatic advance(input bit apply);
    @(posedge CLK);
    if (apply && wr_en) begin
      if (wr_addr != 5'd0) m1[wr_addr] = merge(m1[wr_addr], wr_data, wr_be);
      m2[wr_addr] = merge(m2[wr_addr], wr_data, wr_be);
    end
    #1;
  endtask

  task automatic zero_models();
    for (int i = 0; i < 32; i++) begin m1[i] = '0; m2[i] = '0; end
  endtask

  task automatic test_reset();
    int nbusy = 0, ndone = 0, done_at = -1, first_idle = -1;
    RST = 1'b1; clr_req = 1'b0;
    drive(0, 0, 0, 0, 5'd3, 5'd9);
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      bad++; $display("FAIL reset_state busy=%b done=%b want 1/0", busy1, done1);
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (busy1 === 1'b1) begin
        nbusy++;
        total++;
        if (rd1 !== 64'h0 || rd2 !== 64'h0) begin
          bad++; $display("FAIL reset_rd_zero c=%0d rd1=%h rd2=%h want 0", c, rd1, rd2);
        end
      end else if (first_idle < 0) first_idle = c;
      if (done1 === 1'b1) begin ndone++; done_at = c; end
      total++;
      if (busy2 !== busy1 || done2 !== done1) begin
        bad++; $display("FAIL reset_inst_agree c=%0d b=%b/%b d=%b/%b", c, busy1, busy2, done1, done2);
      end
      @(posedge CLK); #1;
    end
    total++;
    if (nbusy !== 32 || first_idle !== 32) begin
      bad++; $display("FAIL reset_busy_len got=%0d idle_at=%0d want 32/32", nbusy, first_idle);
    end
    total++;
    if (ndone !== 1 || done_at !== 32) begin
      bad++; $display("FAIL reset_done got=%0d at=%0d want 1 at 32", ndone, done_at);
    end
    zero_models();
  endtask

  task automatic test_byte_write();
    logic        we [5] = '{1, 1, 0, 1, 0};
    logic [31:0] wd [5] = '{32'hAABBCCDD, 32'h11223344, 0, 32'h0, 0};
    logic [3:0]  be [5] = '{4'hF, 4'h5, 4'h0, 4'h0, 4'h0};
    logic [31:0] e;
    for (int s = 0; s < 5; s++) begin
      drive(we[s], 5'd5, wd[s], be[s], 5'd5, 5'd5);
      push_reads();
      @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++; $display("FAIL byte_write s=%0d port%0d got=%h want=%h", s, k, obs(k), e);
        end
      end
      if (s == 2 || s == 4) begin
        total++;
        if (rd2[31:0] !== 32'hAA22CC44 || rd1[63:32] !== 32'hAA22CC44) begin
          bad++; $display("FAIL byte_write_const s=%0d got=%h/%h want=aa22cc44", s, rd2[31:0], rd1[63:32]);
        end
      end
      advance(1);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    drive(1, 5'd7, 32'hFFFFFFFF, 4'hF, 5'd3, 5'd4);
    advance(1);
    drive(1, 5'd7, 32'h12345678, 4'h3, 5'd7, 5'd7);
    push_reads();
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      total++;
      if (obs(k) !== e) begin
        bad++; $display("FAIL bypass port%0d got=%h want=%h", k, obs(k), e);
      end
    end
    total++;
    if (rd1 !== {2{32'hFFFF5678}} || rd2 !== {2{32'hFFFFFFFF}}) begin
      bad++; $display("FAIL bypass_const rd1=%h rd2=%h want ffff5678x2/ffffffffx2", rd1, rd2);
    end
    advance(1);
    drive(0, 5'd0, 0, 0, 5'd7, 5'd7);
    @(negedge CLK);
    total++;
    if (rd2 !== {2{32'hFFFF5678}}) begin
      bad++; $display("FAIL bypass_after rd2=%h want ffff5678x2", rd2);
    end
    advance(1);
  endtask

  task automatic test_zero_r0();
    drive(1, 5'd0, 32'hDEADBEEF, 4'hF, 5'd0, 5'd0);
    @(negedge CLK);
    total++;
    if (rd1 !== 64'h0 || rd2[31:0] !== m2[0]) begin
      bad++; $display("FAIL zero_same rd1=%h rd2=%h want 0/%h", rd1, rd2[31:0], m2[0]);
    end
    advance(1);
    for (int s = 0; s < 2; s++) begin
      drive(0, 5'd0, 0, 0, 5'd0, 5'd0);
      @(negedge CLK);
      total++;
      if (rd1 !== 64'h0 || rd2 !== {2{32'hDEADBEEF}}) begin
        bad++; $display("FAIL zero_later s=%0d rd1=%h rd2=%h want 0/deadbeefx2", s, rd1, rd2);
      end
      advance(1);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  wa;
    logic [31:0] e;
    for (int s = 0; s < 24; s++) begin
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31)));
      push_reads();
      @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++; $display("FAIL back_to_back s=%0d port%0d got=%h want=%h", s, k, obs(k), e);
        end
      end
      advance(1);
    end
  endtask

  task automatic test_clear_req();
    int nbusy = 0, ndone = 0, done_at = -1;
    logic [31:0] e;
    for (int a = 1; a < 32; a++) begin
      drive(1, 5'(a), $urandom | 32'h1, 4'hF, 5'd1, 5'd2);
      advance(1);
    end
    drive(1, 5'd3, 32'h99, 4'hF, 5'd3, 5'd9);
    clr_req = 1'b1;
    @(negedge CLK);
    total++;
    if (busy1 !== 1'b0) begin
      bad++; $display("FAIL clr_accept_cycle busy=%b want 0", busy1);
    end
    @(posedge CLK); #1;
    clr_req = 1'b0;
    drive(0, 0, 0, 0, 5'd3, 5'd9);
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (busy1 === 1'b1) begin
        nbusy++;
        total++;
        if (rd1 !== 64'h0) begin
          bad++; $display("FAIL clr_rd_zero c=%0d rd1=%h want 0", c, rd1);
        end
      end
      if (done1 === 1'b1) begin ndone++; done_at = c; end
      clr_req = (c == 5);
      if (c == 10) drive(1, 5'd9, 32'h5555, 4'hF, 5'd3, 5'd9);
      else drive(0, 0, 0, 0, 5'd3, 5'd9);
      @(posedge CLK); #1;
    end
    clr_req = 1'b0;
    total++;
    if (nbusy !== 32 || ndone !== 1 || done_at !== 33) begin
      bad++; $display("FAIL clr_timing busy=%0d done=%0d at=%0d want 32/1/33", nbusy, ndone, done_at);
    end
    zero_models();
    for (int a = 0; a < 32; a += 2) begin
      drive(0, 0, 0, 0, 5'(a), 5'(a + 1));
      push_reads();
      @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(k) !== e) begin
          bad++; $display("FAIL clr_contents a=%0d port%0d got=%h want=%h", a, k, obs(k), e);
        end
      end
      advance(1);
    end
  endtask

  task automatic test_rst_mid_clear();
    int nbusy = 0, ndone = 0, done_at = -1;
    drive(1, 5'd12, 32'hCAFEF00D, 4'hF, 5'd12, 5'd12);
    advance(1);
    drive(0, 0, 0, 0, 5'd12, 5'd12);
    clr_req = 1'b1;
    advance(0);
    clr_req = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      if (done1 === 1'b1) ndone++;
      total++;
      if (busy1 !== 1'b1) begin
        bad++; $display("FAIL rst_mid_pre c=%0d busy=%b want 1", c, busy1);
      end
      if (c == 15) RST = 1'b1;
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    for (int d = 0; d < 40; d++) begin
      @(negedge CLK);
      if (busy1 === 1'b1) nbusy++;
      if (done1 === 1'b1) begin ndone++; done_at = d; end
      @(posedge CLK); #1;
    end
    total++;
    if (nbusy !== 32 || ndone !== 1 || done_at !== 32) begin
      bad++; $display("FAIL rst_mid busy=%0d done=%0d at=%0d want 32/1/32", nbusy, ndone, done_at);
    end
    @(negedge CLK);
    total++;
    if (rd1 !== 64'h0 || rd2 !== 64'h0) begin
      bad++; $display("FAIL rst_mid_contents rd1=%h rd2=%h want 0", rd1, rd2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_write();
    test_bypass();
    test_zero_r0();
    test_back_to_back();
    test_clear_req();
    test_rst_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
